// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator: shared period counter, debounced inc/dec buttons,
// per-channel shadowed duty registers, edge- or center-aligned modulation.

module pwm_chan #(
  parameter int CW     = 8,
  parameter int PERIOD = 100,
  parameter int STEP   = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_inc,
  input  logic          i_dec,
  input  logic          i_ld,
  input  logic [CW-1:0] i_cnt,
  output logic          o_pwm,
  output logic [CW-1:0] o_duty
);
  localparam logic [CW:0]   STEPX = (CW+1)'(STEP);
  localparam logic [CW:0]   PX    = (CW+1)'(PERIOD);
  localparam logic [CW-1:0] PMAX  = CW'(PERIOD);
  localparam logic [CW-1:0] HALF  = CW'(PERIOD / 2);

  logic [CW-1:0] r_duty, r_act;
  logic          r_pwm;
  logic [CW:0]   w_up, w_dn;

  // one extra bit so the sum/difference never wraps before saturation
  assign w_up = {1'b0, r_duty} + STEPX;
  assign w_dn = {1'b0, r_duty} - STEPX;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_duty <= HALF;
      r_act  <= HALF;
      r_pwm  <= 1'b0;
    end else begin
      if (i_inc && !i_dec)      r_duty <= (w_up > PX) ? PMAX : w_up[CW-1:0];
      else if (i_dec && !i_inc) r_duty <= w_dn[CW] ? '0 : w_dn[CW-1:0];
      if (i_ld) r_act <= r_duty;
      r_pwm <= i_en && (i_cnt < r_act);
    end
  end

  assign o_pwm  = r_pwm;
  assign o_duty = r_duty;
endmodule

module pwm_multi_ctrl #(
  parameter int CH      = 4,
  parameter int CW      = 8,
  parameter int PERIOD  = 100,
  parameter int STEP    = 10,
  parameter int DEB_DIV = 250000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic                                 mode,
  input  logic                                 inc_btn,
  input  logic                                 dec_btn,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ch_sel,
  output logic [CH-1:0]                        pwm_out,
  output logic [CW-1:0]                        duty_out,
  output logic                                 period_start
);
  localparam int            SW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int            TW   = $clog2(DEB_DIV);
  localparam logic [TW-1:0] TEND = TW'(DEB_DIV - 1);
  localparam logic [CW-1:0] P_M1 = CW'(PERIOD - 1);

  logic [TW-1:0]           r_tdiv;
  logic                    r_inc_s1, r_inc_s2, r_dec_s1, r_dec_s2;
  logic [CW-1:0]           r_cnt;
  logic                    r_dir;    // 1 = counting down (center mode only)
  logic                    r_amode;
  logic                    w_tick, w_inc_p, w_dec_p, w_pend, w_ld;
  logic [CH-1:0][CW-1:0]   w_duty;

  assign w_tick  = (r_tdiv == TEND);
  assign w_inc_p = r_inc_s1 && !r_inc_s2 && w_tick;
  assign w_dec_p = r_dec_s1 && !r_dec_s2 && w_tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tdiv   <= '0;
      r_inc_s1 <= 1'b0;
      r_inc_s2 <= 1'b0;
      r_dec_s1 <= 1'b0;
      r_dec_s2 <= 1'b0;
    end else begin
      r_tdiv <= w_tick ? '0 : r_tdiv + 1'b1;
      if (w_tick) begin
        r_inc_s1 <= inc_btn;
        r_inc_s2 <= r_inc_s1;
        r_dec_s1 <= dec_btn;
        r_dec_s2 <= r_dec_s1;
      end
    end
  end

  assign w_pend = r_amode ? (r_dir && (r_cnt == '0)) : (r_cnt == P_M1);
  // disabled: shadows track the programmed values every cycle
  assign w_ld   = !en || w_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_amode <= 1'b0;
    end else begin
      if (w_ld) begin
        r_cnt <= '0;
        r_dir <= 1'b0;
      end else if (!r_amode || !r_dir) begin
        // center mode holds the top count one extra cycle while turning around
        if (r_amode && (r_cnt == P_M1)) r_dir <= 1'b1;
        else                            r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_ld) r_amode <= mode;
    end
  end

  assign period_start = en && (r_cnt == '0) && !r_dir;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic w_sel;
    assign w_sel = (ch_sel == SW'(i));
    pwm_chan #(.CW(CW), .PERIOD(PERIOD), .STEP(STEP)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (en),
      .i_inc  (w_inc_p && w_sel),
      .i_dec  (w_dec_p && w_sel),
      .i_ld   (w_ld),
      .i_cnt  (r_cnt),
      .o_pwm  (pwm_out[i]),
      .o_duty (w_duty[i])
    );
  end

  always_comb begin
    duty_out = '0;
    for (int i = 0; i < CH; i++)
      if (ch_sel == SW'(i)) duty_out = w_duty[i];
  end
endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Self-checking bench for pwm_multi_ctrl: table of button sequences with a duty
// scoreboard, plus hand sequences for waveform, glitch, mode and reset cases.
module tb_pwm_multi_ctrl;
  localparam int CH = 2, CW = 8, PERIOD = 10, STEP = 1, DEB_DIV = 2;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0;
  logic          inc_btn = 1'b0, dec_btn = 1'b0;
  logic [0:0]    ch_sel = 1'b0;
  logic [CH-1:0] pwm_out;
  logic [CW-1:0] duty_out;
  logic          period_start;

  pwm_multi_ctrl #(.CH(CH), .CW(CW), .PERIOD(PERIOD), .STEP(STEP), .DEB_DIV(DEB_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .ch_sel(ch_sel), .pwm_out(pwm_out), .duty_out(duty_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    int         n_inc;
    int         n_dec;
    logic [7:0] exp_duty;
  } vec_t;

  int         checks = 0, errors = 0;
  int         tb_ph;            // edges since reset release: debounce phase is tb_ph % DEB_DIV
  logic [7:0] sb_q[$];
  vec_t       tbl[10];

  always @(posedge clk) begin
    if (!rst_n) tb_ph <= 0;
    else        tb_ph <= tb_ph + 1;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sb_check(input string nm);
    logic [7:0] e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      chk(nm, duty_out, e);
    end
  endtask

  task automatic press(input logic i, input logic d);
    inc_btn = i; dec_btn = d;
    cyc(6);
    inc_btn = 1'b0; dec_btn = 1'b0;
    cyc(6);
  endtask

  task automatic wait_ps();
    int n = 0;
    while (period_start !== 1'b1 && n < 50) begin cyc(1); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL wait_period_start: no period_start within 50 cycles");
    end
  endtask

  task automatic measure(input int n, output int h0, output int h1, output int ps);
    h0 = 0; h1 = 0; ps = 0;
    for (int k = 0; k < n; k++) begin
      cyc(1);
      h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]); ps += int'(period_start);
    end
  endtask

  initial begin
    int   h0, h1, ps, ha, hb;
    logic p0[41], p1[41], pss[41];
    logic [7:0] run;

    tbl[0] = '{1'b1, 1, 0, 8'd6};
    tbl[1] = '{1'b1, 1, 0, 8'd7};
    tbl[2] = '{1'b1, 1, 0, 8'd8};
    tbl[3] = '{1'b1, 1, 0, 8'd9};
    tbl[4] = '{1'b1, 1, 0, 8'd10};
    tbl[5] = '{1'b1, 2, 0, 8'd10};
    tbl[6] = '{1'b0, 0, 0, 8'd5};
    tbl[7] = '{1'b1, 0, 5, 8'd5};
    tbl[8] = '{1'b1, 0, 7, 8'd0};
    tbl[9] = '{1'b1, 0, 1, 8'd0};

    // reset state
    cyc(3);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_duty0", duty_out, 5);
    chk("rst_ps_en0", period_start, 0);
    ch_sel = 1'b1; #1;
    chk("rst_duty1", duty_out, 5);
    ch_sel = 1'b0;

    // default 50% edge-aligned
    rst_n = 1'b1; en = 1'b1;
    cyc(1);
    wait_ps();
    measure(20, h0, h1, ps);
    chk("edge_hi0", h0, 10);
    chk("edge_hi1", h1, 10);
    chk("edge_ps", ps, 2);

    // button table: saturation up, channel isolation, saturation down
    for (int i = 0; i < 10; i++) begin
      ch_sel = tbl[i].sel;
      sb_q.push_back(tbl[i].exp_duty);
      repeat (tbl[i].n_inc) press(1'b1, 1'b0);
      repeat (tbl[i].n_dec) press(1'b0, 1'b1);
      cyc(1);
      sb_check($sformatf("tbl%0d_duty", i));
      if (i == 5 || i == 9) begin
        wait_ps();
        measure(10, h0, h1, ps);
        chk($sformatf("tbl%0d_hi1", i), h1, (i == 5) ? 10 : 0);
        chk($sformatf("tbl%0d_hi0", i), h0, 5);
      end
    end

    // single-cycle glitch between ticks, held button, simultaneous inc+dec
    ch_sel = 1'b1;
    while (tb_ph[0] != 1'b0) cyc(1);
    sb_q.push_back(8'd0);
    inc_btn = 1'b1; cyc(1); inc_btn = 1'b0;
    cyc(8);
    sb_check("glitch_duty");
    sb_q.push_back(8'd1);
    inc_btn = 1'b1; cyc(50); inc_btn = 1'b0; cyc(6);
    sb_check("held_duty");
    sb_q.push_back(8'd1);
    press(1'b1, 1'b1);
    sb_check("incdec_duty");

    // duty change mid-period: old high time, then new
    wait_ps();
    sb_q.push_back(8'd2);
    inc_btn = 1'b1;
    ha = 0; hb = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (k <= 10) ha += int'(pwm_out[1]); else hb += int'(pwm_out[1]);
      if (k == 6) begin inc_btn = 1'b0; sb_check("mid_duty"); end
    end
    chk("mid_old_hi", ha, 1);
    chk("mid_new_hi", hb, 2);

    // center-aligned with duty 3, mode change taken at the boundary
    sb_q.push_back(8'd3);
    press(1'b1, 1'b0);
    sb_check("ctr_duty");
    wait_ps();
    mode = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      p0[k] = pwm_out[0]; p1[k] = pwm_out[1]; pss[k] = period_start;
    end
    ha = 0; hb = 0; h0 = 0; ps = 0;
    for (int k = 1; k <= 10; k++) ha += int'(p1[k]);
    for (int k = 11; k <= 30; k++) begin hb += int'(p1[k]); h0 += int'(p0[k]); end
    for (int k = 11; k <= 29; k++) ps += int'(pss[k]);
    for (int k = 0; k < 8; k++) run[7-k] = p1[27+k];
    chk("ctr_first_edge_hi", ha, 3);
    chk("ctr_ps10", pss[10], 1);
    chk("ctr_ps30", pss[30], 1);
    chk("ctr_ps_between", ps, 0);
    chk("ctr_hi1", hb, 6);
    chk("ctr_hi0", h0, 10);
    chk("ctr_contig", run, 8'b0111_1110);

    // synchronous reset mid-period after duties moved
    ch_sel = 1'b0;
    sb_q.push_back(8'd6);
    press(1'b1, 1'b0);
    sb_check("pre_rst_duty0");
    wait_ps();
    cyc(4);
    rst_n = 1'b0; mode = 1'b0;
    cyc(1);
    chk("mid_rst_pwm", pwm_out, 0);
    chk("mid_rst_duty0", duty_out, 5);
    chk("mid_rst_cnt0", period_start, 1);
    ch_sel = 1'b1; #1;
    chk("mid_rst_duty1", duty_out, 5);
    rst_n = 1'b1;

    // disabled: outputs low, buttons still program duty
    en = 1'b0;
    cyc(1);
    sb_q.push_back(8'd6);
    inc_btn = 1'b1;
    measure(6, h0, h1, ps);
    inc_btn = 1'b0;
    measure(6, ha, hb, ps);
    chk("dis_hi", h0 + h1 + ha + hb, 0);
    chk("dis_ps", ps, 0);
    sb_check("dis_duty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
